// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute and
// drives datapath selects, with memory wait timeout and sticky faults.
module multicycle_controller #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int SUPPORT_BNE   = 1,
  parameter int MAX_WAIT      = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       IllegalInstr,
  output logic       BusFault,
  output logic [3:0] State
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] JAL      = 4'd8;
  localparam logic [3:0] ALUWB    = 4'd9;
  localparam logic [3:0] BRANCH   = 4'd10;
  localparam logic [3:0] ILLEGAL  = 4'd11;
  localparam logic [3:0] FAULT    = 4'd12;

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

  logic [3:0]    state, next;
  logic [CW-1:0] cnt, cnt_n;
  logic          ill_q, bf_q;
  logic          ready, mem_st, timeout;
  logic [1:0]    alu_op;

  assign ready   = MemReady | (MEM_HANDSHAKE == 0);
  assign mem_st  = (state == FETCH) || (state == MEMREAD) ||
                   (state == MEMWRITE);
  assign timeout = (MAX_WAIT != 0) && mem_st && !ready && (cnt == WMAX);

  always_comb begin
    next = state;
    case (state)
      FETCH:    if (ready) next = DECODE;
      DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: next = MEMADR;
          7'b0110011:             next = EXECUTER;
          7'b0010011:             next = EXECUTEI;
          7'b1101111:             next = JAL;
          7'b1100011: begin
            if (funct3 == 3'b000 ||
                (funct3 == 3'b001 && SUPPORT_BNE != 0))
              next = BRANCH;
            else
              next = ILLEGAL;
          end
          default:                next = ILLEGAL;
        endcase
      end
      MEMADR:   next = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (ready) next = MEMWB;
      MEMWB:    next = FETCH;
      MEMWRITE: if (ready) next = FETCH;
      EXECUTER: next = ALUWB;
      EXECUTEI: next = ALUWB;
      JAL:      next = ALUWB;
      ALUWB:    next = FETCH;
      BRANCH:   next = FETCH;
      ILLEGAL:  next = ILLEGAL;
      FAULT:    next = FAULT;
      default:  next = FETCH;
    endcase
    if (timeout) next = FAULT;
  end

  // Counter only runs while stalled in the same memory state.
  always_comb begin
    cnt_n = '0;
    if (mem_st && !ready && next == state) cnt_n = cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      cnt   <= '0;
      ill_q <= 1'b0;
      bf_q  <= 1'b0;
    end else begin
      state <= next;
      cnt   <= cnt_n;
      ill_q <= ill_q | (next == ILLEGAL);
      bf_q  <= bf_q | (next == FAULT);
    end
  end

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    RegWrite  = 1'b0;
    alu_op    = 2'b00;
    case (state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = ready;
        PCWrite   = ready;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      ALUWB:    RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        PCWrite = (funct3 == 3'b000 & Zero) |
                  (funct3 == 3'b001 & ~Zero);
      end
      default: ;
    endcase
  end

  always_comb begin
    case (alu_op)
      2'b01:   ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

  assign IllegalInstr = ill_q;
  assign BusFault     = bf_q;
  assign State        = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: two instances (default
// parameters, and SUPPORT_BNE=0 / MAX_WAIT=4) checked cycle by cycle.
module tb_multicycle_controller;

  localparam logic [3:0] S_F   = 4'd0;
  localparam logic [3:0] S_D   = 4'd1;
  localparam logic [3:0] S_MA  = 4'd2;
  localparam logic [3:0] S_MR  = 4'd3;
  localparam logic [3:0] S_MWB = 4'd4;
  localparam logic [3:0] S_MW  = 4'd5;
  localparam logic [3:0] S_XR  = 4'd6;
  localparam logic [3:0] S_XI  = 4'd7;
  localparam logic [3:0] S_J   = 4'd8;
  localparam logic [3:0] S_AWB = 4'd9;
  localparam logic [3:0] S_BR  = 4'd10;
  localparam logic [3:0] S_IL  = 4'd11;
  localparam logic [3:0] S_FT  = 4'd12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, funct7b5, Zero, MemReady;
  logic [6:0] op;
  logic [2:0] funct3;

  logic       a_pcw, a_adr, a_mw, a_irw, a_rw, a_ill, a_bf;
  logic [1:0] a_rs, a_sa, a_sb, a_imm;
  logic [2:0] a_ac;
  logic [3:0] a_st;
  logic       b_pcw, b_adr, b_mw, b_irw, b_rw, b_ill, b_bf;
  logic [1:0] b_rs, b_sa, b_sb, b_imm;
  logic [2:0] b_ac;
  logic [3:0] b_st;

  multicycle_controller dut_a (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(a_pcw), .AdrSrc(a_adr), .MemWrite(a_mw),
    .IRWrite(a_irw), .ResultSrc(a_rs), .ALUSrcA(a_sa),
    .ALUSrcB(a_sb), .RegWrite(a_rw), .ImmSrc(a_imm),
    .ALUControl(a_ac), .IllegalInstr(a_ill), .BusFault(a_bf),
    .State(a_st)
  );

  multicycle_controller #(
    .MEM_HANDSHAKE(1), .SUPPORT_BNE(0), .MAX_WAIT(4)
  ) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(b_pcw), .AdrSrc(b_adr), .MemWrite(b_mw),
    .IRWrite(b_irw), .ResultSrc(b_rs), .ALUSrcA(b_sa),
    .ALUSrcB(b_sb), .RegWrite(b_rw), .ImmSrc(b_imm),
    .ALUControl(b_ac), .IllegalInstr(b_ill), .BusFault(b_bf),
    .State(b_st)
  );

  logic [21:0] obs_a, obs_b;
  assign obs_a = {a_st, a_pcw, a_irw, a_mw, a_rw, a_rs, a_sa, a_sb,
                  a_adr, a_ac, a_ill, a_bf, a_imm};
  assign obs_b = {b_st, b_pcw, b_irw, b_mw, b_rw, b_rs, b_sa, b_sb,
                  b_adr, b_ac, b_ill, b_bf, b_imm};

  typedef struct {
    string       name;
    bit          sel;
    logic [21:0] v;
  } rec_t;

  rec_t q[$];
  int   tests = 0;
  int   fails = 0;

  string      tname;
  bit         tsel;
  logic [1:0] timm;

  function automatic logic [19:0] mk(
    input logic [3:0] st, input logic pcw, input logic irw,
    input logic mw, input logic rw, input logic [1:0] rs,
    input logic [1:0] sa, input logic [1:0] sb, input logic adr,
    input logic [2:0] ac, input logic ill, input logic bf);
    return {st, pcw, irw, mw, rw, rs, sa, sb, adr, ac, ill, bf};
  endfunction

  function automatic logic [19:0] ef(input logic r);
    return mk(S_F, r, r, 0, 0, 2'b10, 2'b00, 2'b10, 0, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] ed();
    return mk(S_D, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] ema();
    return mk(S_MA, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] emr();
    return mk(S_MR, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] emwb();
    return mk(S_MWB, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 0, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] emw();
    return mk(S_MW, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] exr(input logic [2:0] ac);
    return mk(S_XR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, ac, 0, 0);
  endfunction
  function automatic logic [19:0] exi(input logic [2:0] ac);
    return mk(S_XI, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, ac, 0, 0);
  endfunction
  function automatic logic [19:0] ej();
    return mk(S_J, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] eawb();
    return mk(S_AWB, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] ebr(input logic p);
    return mk(S_BR, p, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b001, 0, 0);
  endfunction
  function automatic logic [19:0] eil();
    return mk(S_IL, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 1, 0);
  endfunction
  function automatic logic [19:0] eft();
    return mk(S_FT, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0, 1);
  endfunction

  task automatic exp_push(input logic [19:0] v);
    rec_t r;
    r.name = tname;
    r.sel  = tsel;
    r.v    = {v, timm};
    q.push_back(r);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic rdy, input logic z,
                      input logic [19:0] v);
    reset    = 1'b0;
    MemReady = rdy;
    Zero     = z;
    exp_push(v);
    cyc();
  endtask

  task automatic instr(input string n, input bit sel,
                       input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic [1:0] imm);
    tname    = n;
    tsel     = sel;
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    timm     = imm;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    MemReady = 1'b0;
    cyc();
  endtask

  rec_t        mr;
  logic [21:0] mo;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mr = q.pop_front();
      mo = mr.sel ? obs_b : obs_a;
      tests++;
      if (mo !== mr.v) begin
        fails++;
        $display("FAIL %s: got %b want %b", mr.name, mo, mr.v);
      end
    end
  end

  initial begin
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    Zero = 1'b0; MemReady = 1'b0;
    cyc();
    cyc();
    instr("reset_a", 0, 7'b0000000, 3'b000, 0, 2'b00);
    exp_push(ef(0)); cyc();
    instr("reset_b", 1, 7'b0000000, 3'b000, 0, 2'b00);
    exp_push(ef(0)); cyc();

    instr("lw", 0, 7'b0000011, 3'b010, 0, 2'b00);
    step(1, 0, ef(1)); step(1, 0, ed()); step(1, 0, ema());
    step(1, 0, emr()); step(1, 0, emwb());

    instr("sub", 0, 7'b0110011, 3'b000, 1, 2'b00);
    step(1, 0, ef(1)); step(1, 0, ed());
    step(1, 0, exr(3'b001)); step(1, 0, eawb());
    instr("slt", 0, 7'b0110011, 3'b010, 0, 2'b00);
    step(1, 0, ef(1)); step(1, 0, ed());
    step(1, 0, exr(3'b101)); step(1, 0, eawb());
    instr("and", 0, 7'b0110011, 3'b111, 0, 2'b00);
    step(1, 0, ef(1)); step(1, 0, ed());
    step(1, 0, exr(3'b010)); step(1, 0, eawb());
    instr("sll_add", 0, 7'b0110011, 3'b001, 1, 2'b00);
    step(1, 0, ef(1)); step(1, 0, ed());
    step(1, 0, exr(3'b000)); step(1, 0, eawb());
    instr("addi_f7", 0, 7'b0010011, 3'b000, 1, 2'b00);
    step(1, 0, ef(1)); step(1, 0, ed());
    step(1, 0, exi(3'b000)); step(1, 0, eawb());
    instr("ori", 0, 7'b0010011, 3'b110, 0, 2'b00);
    step(1, 0, ef(1)); step(1, 0, ed());
    step(1, 0, exi(3'b011)); step(1, 0, eawb());

    instr("beq_z1", 0, 7'b1100011, 3'b000, 0, 2'b10);
    step(1, 1, ef(1)); step(1, 1, ed()); step(1, 1, ebr(1));
    instr("beq_z0", 0, 7'b1100011, 3'b000, 0, 2'b10);
    step(1, 0, ef(1)); step(1, 0, ed()); step(1, 0, ebr(0));
    instr("bne_z1", 0, 7'b1100011, 3'b001, 0, 2'b10);
    step(1, 1, ef(1)); step(1, 1, ed()); step(1, 1, ebr(0));
    instr("bne_z0", 0, 7'b1100011, 3'b001, 0, 2'b10);
    step(1, 0, ef(1)); step(1, 0, ed()); step(1, 0, ebr(1));

    instr("jal", 0, 7'b1101111, 3'b000, 0, 2'b11);
    step(1, 0, ef(1)); step(1, 0, ed());
    step(1, 0, ej()); step(1, 0, eawb());

    instr("sw_wait", 0, 7'b0100011, 3'b010, 0, 2'b01);
    step(1, 0, ef(1)); step(1, 0, ed()); step(1, 0, ema());
    for (int i = 0; i < 3; i++) step(0, 0, emw());
    step(1, 0, emw());
    step(0, 0, ef(0));

    instr("lw_wait", 0, 7'b0000011, 3'b010, 0, 2'b00);
    step(1, 0, ef(1)); step(1, 0, ed()); step(1, 0, ema());
    step(0, 0, emr()); step(0, 0, emr());
    step(1, 0, emr()); step(1, 0, emwb());

    instr("fetch_wait15", 0, 7'b0110011, 3'b000, 0, 2'b00);
    for (int i = 0; i < 15; i++) step(0, 0, ef(0));
    step(1, 0, ef(1)); step(1, 0, ed());
    step(1, 0, exr(3'b000)); step(1, 0, eawb());

    instr("illegal", 0, 7'b0000000, 3'b000, 0, 2'b00);
    step(1, 0, ef(1)); step(1, 0, ed());
    step(1, 0, eil()); step(1, 0, eil());
    do_reset();

    instr("bne_nosupp", 1, 7'b1100011, 3'b001, 0, 2'b10);
    step(1, 1, ef(1)); step(1, 1, ed()); step(1, 1, eil());
    instr("ill_sticky", 1, 7'b0110011, 3'b000, 0, 2'b00);
    step(1, 0, eil()); step(1, 0, eil());
    do_reset();
    tname = "ill_clear";
    step(0, 0, ef(0));
    instr("beq_b", 1, 7'b1100011, 3'b000, 0, 2'b10);
    step(1, 1, ef(1)); step(1, 1, ed()); step(1, 1, ebr(1));

    instr("fetch_fault", 1, 7'b0000011, 3'b000, 0, 2'b00);
    for (int i = 0; i < 5; i++) step(0, 0, ef(0));
    step(0, 0, eft()); step(1, 0, eft());
    do_reset();
    tname = "bf_clear";
    step(0, 0, ef(0));

    instr("rst_mw", 0, 7'b0100011, 3'b010, 0, 2'b01);
    step(1, 0, ef(1)); step(1, 0, ed()); step(1, 0, ema());
    step(0, 0, emw());
    reset    = 1'b1;
    MemReady = 1'b0;
    exp_push(ef(0));
    cyc();
    step(0, 0, ef(0));

    cyc();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle RISC-V control unit; successor to the single-cycle controller.
- Moore FSM sequences fetch/decode/execute over several cycles and drives datapath muxes and enables.
- Adds a memory ready handshake with a bounded wait timeout, bne support, and sticky illegal-instruction and bus-fault reporting.
- Sits between the instruction register and the shared instruction/data memory port of the multi-cycle datapath.

Parameters:
- MEM_HANDSHAKE, 1: 1 = honour MemReady; 0 = MemReady treated as constant 1.
- SUPPORT_BNE, 1: 1 = branch funct3 001 (bne) legal; 0 = it decodes as illegal.
- MAX_WAIT, 15: maximum consecutive MemReady-low cycles tolerated in a memory state; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  7  instruction opcode, from the IR
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR and OldPC enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = register A
- ALUSrcB  out  2  00 = register B, 01 = ImmExt, 10 = constant 4
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J; decoded combinationally from op
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- IllegalInstr  out  1  sticky; cleared only by reset
- BusFault  out  1  sticky; cleared only by reset
- State  out  4  current state encoding, for debug

Behaviour:
- Reset (asynchronous): State = FETCH, wait counter = 0, IllegalInstr = 0, BusFault = 0.
- All outputs are combinational from state, plus Zero/funct3 in BRANCH and MemReady in memory states.
- Default for every output is 0; ALUControl defaults to add.
- ALUOp encoding: 00 = add, 01 = sub, 10 = funct-decoded.
- Funct decode (ALUOp 10):
  - funct3 000: sub if (funct7b5 & op[5]), else add.
  - funct3 010: slt.
  - funct3 110: or.
  - funct3 111: and.
  - Any other funct3: add.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite = PCWrite = MemReady.
  - Stay while MemReady is low; go to DECODE on MemReady.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut). Next state by op:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 with funct3 000, or 001 when SUPPORT_BNE=1 -> BRANCH
  - anything else -> ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. op[5]=0 -> MEMREAD; op[5]=1 -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite held until MemReady, then FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next: ALUWB (writes PC+4).
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = (funct3==000 & Zero) | (funct3==001 & ~Zero).
  - Next: FETCH.
- ILLEGAL: terminal; all enables 0, IllegalInstr=1.
- FAULT: terminal; all enables 0, BusFault=1.
- Wait counter (states FETCH, MEMREAD, MEMWRITE):
  - Increments each cycle MemReady is low; clears on MemReady or on leaving the state.
  - When MAX_WAIT != 0 and counter == MAX_WAIT with MemReady still low: next state = FAULT.
  - Width = clog2(MAX_WAIT+1), minimum 1 bit.
- MemReady in non-memory states is ignored.
- Cycle counts with MemReady=1: lw 5, sw 4, R/I 4, jal 4, branch 3.
- Reset asserted mid-instruction: immediate return to FETCH; any MemWrite/RegWrite drops asynchronously.

Test Plan:
- Reset, MemReady=1, op=0000011 (lw) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5; ResultSrc=01.
- op=0110011, funct3=000, funct7b5=1 -> EXECUTER with ALUControl=001; RegWrite=1 in ALUWB; 4 cycles total.
- beq with Zero=1 -> PCWrite=1 in BRANCH; bne with Zero=1 -> PCWrite=0; bne with SUPPORT_BNE=0 -> ILLEGAL, IllegalInstr=1 until reset.
- sw with MemReady low for 3 cycles (MAX_WAIT=15) -> MemWrite high for 4 cycles, then FETCH, BusFault=0.
- MAX_WAIT=4, MemReady held low in FETCH -> FAULT entered after the 5th low cycle; BusFault=1; IRWrite never asserted.
- Reset pulsed during MEMWRITE -> MemWrite=0 asynchronously; State=FETCH; sticky flags cleared.
